// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate extender: widens an N-bit immediate by mode and queues the result
// in a 2-entry elastic buffer behind a valid/ready handshake.
module imm_extend_pipe #(
  parameter int unsigned N          = 16,
  parameter int unsigned FINAL_SIZE = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N-1:0]          in_data_i,
  input  logic [1:0]            in_mode_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [FINAL_SIZE-1:0] out_data_o,
  output logic [1:0]            count_o
);

  // Branch mode shifts the sign-extended value left by two; it needs two spare bits.
  if (FINAL_SIZE < N + 2) begin : gen_width_check
    $error("imm_extend_pipe: FINAL_SIZE must be >= N+2");
  end

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e                state_q;
  logic [FINAL_SIZE-1:0] head_q;
  logic [FINAL_SIZE-1:0] tail_q;
  logic [FINAL_SIZE-1:0] sext;
  logic [FINAL_SIZE-1:0] ext;
  logic                  push;
  logic                  pop;

  assign sext = {{(FINAL_SIZE-N){in_data_i[N-1]}}, in_data_i};

  always_comb begin
    ext = sext;
    unique case (in_mode_i)
      2'b00: ext = sext;
      2'b01: ext = {{(FINAL_SIZE-N){1'b0}}, in_data_i};
      2'b10: ext = {in_data_i, {(FINAL_SIZE-N){1'b0}}};
      2'b11: ext = {sext[FINAL_SIZE-3:0], 2'b00};
      default: ext = sext;
    endcase
  end

  assign in_ready_o  = !rst_i && !flush_i && (state_q != StFull);
  assign out_valid_o = (state_q != StEmpty);
  assign out_data_o  = head_q;
  assign count_o     = state_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            head_q  <= ext;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_q <= ext;
          end else if (push) begin
            tail_q  <= ext;
            state_q <= StFull;
          end else if (pop) begin
            head_q  <= '0;
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_q  <= tail_q;
            tail_q  <= '0;
            state_q <= StOne;
          end
        end
        default: begin
          state_q <= StEmpty;
          head_q  <= '0;
          tail_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed-vector and random-stream bench for imm_extend_pipe (N=16, FINAL_SIZE=32).
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  imm_extend_pipe #(
    .N         (16),
    .FINAL_SIZE(32)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_mode_i  (in_mode),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .count_o    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hold(input logic [15:0] d, input logic [1:0] m);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] model_ext(input logic [15:0] d, input logic [1:0] m);
    logic [31:0] s;
    s = d[15] ? (32'hFFFF0000 | 32'(d)) : 32'(d);
    case (m)
      2'b00:   return s;
      2'b01:   return 32'(d);
      2'b10:   return 32'(d) * 32'h10000;
      default: return s * 32'd4;
    endcase
  endfunction

  vec_t        vecs[10];
  logic [31:0] q[$];
  logic        m_push;
  logic        m_pop;

  initial begin
    vecs[0] = '{16'hFFFE, 2'b00, 32'hFFFFFFFE};
    vecs[1] = '{16'hFFFE, 2'b01, 32'h0000FFFE};
    vecs[2] = '{16'hFFFE, 2'b10, 32'hFFFE0000};
    vecs[3] = '{16'hFFFE, 2'b11, 32'hFFFFFFF8};
    vecs[4] = '{16'h7FFF, 2'b11, 32'h0001FFFC};
    vecs[5] = '{16'h8000, 2'b00, 32'hFFFF8000};
    vecs[6] = '{16'h8000, 2'b01, 32'h00008000};
    vecs[7] = '{16'h1234, 2'b10, 32'h12340000};
    vecs[8] = '{16'h8000, 2'b11, 32'hFFFE0000};
    vecs[9] = '{16'h0001, 2'b11, 32'h00000004};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'h5A5A; in_mode = 2'b00;
    out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Back-to-back pushes with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      in_mode  = vecs[i].mode;
      step();
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      check($sformatf("vec%0d_count", i), 32'(count), 1);
    end
    in_valid = 1'b0;
    step();
    check("drain_count", 32'(count), 0);
    check("drain_valid", 32'(out_valid), 0);

    // Stall: fill to two, hold head, then drain in order.
    out_ready = 1'b0;
    push_hold(16'h1234, 2'b10);
    check("stall_count1", 32'(count), 1);
    check("stall_head1", out_data, 32'h12340000);
    push_hold(16'h8000, 2'b11);
    check("stall_count2", 32'(count), 2);
    check("stall_in_ready", 32'(in_ready), 0);
    check("stall_head2", out_data, 32'h12340000);
    push_hold(16'hDEAD, 2'b01);
    check("full_ignore_count", 32'(count), 2);
    check("full_ignore_head", out_data, 32'h12340000);
    out_ready = 1'b1;
    step();
    check("drain1_count", 32'(count), 1);
    check("drain1_data", out_data, 32'hFFFE0000);
    step();
    check("drain2_count", 32'(count), 0);

    // Simultaneous push and pop at count 1.
    out_ready = 1'b0;
    push_hold(16'h5555, 2'b01);
    check("pp_pre", out_data, 32'h00005555);
    out_ready = 1'b1;
    push_hold(16'h0001, 2'b00);
    check("pp_count", 32'(count), 1);
    check("pp_data", out_data, 32'h00000001);
    step();
    check("pp_drain", 32'(count), 0);

    // Flush with a full buffer and a coincident push and pop.
    out_ready = 1'b0;
    push_hold(16'h1111, 2'b00);
    push_hold(16'h2222, 2'b00);
    check("fl_full", 32'(count), 2);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h3333; out_ready = 1'b1;
    #1;
    check("fl_in_ready", 32'(in_ready), 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count", 32'(count), 0);
    check("fl_valid", 32'(out_valid), 0);
    check("fl_data", out_data, 0);
    out_ready = 1'b0;
    push_hold(16'hABCD, 2'b01);
    check("fl_after_count", 32'(count), 1);
    check("fl_after_data", out_data, 32'h0000ABCD);
    out_ready = 1'b1;
    step();

    // Reset mid-stream with a full buffer.
    out_ready = 1'b0;
    push_hold(16'h4444, 2'b00);
    push_hold(16'h6666, 2'b00);
    rst = 1'b1;
    step();
    check("rs_count", 32'(count), 0);
    check("rs_valid", 32'(out_valid), 0);
    check("rs_in_ready", 32'(in_ready), 0);
    check("rs_data", out_data, 0);
    rst = 1'b0;
    push_hold(16'h7FFF, 2'b11);
    check("rs_after_count", 32'(count), 1);
    check("rs_after_data", out_data, 32'h0001FFFC);
    out_ready = 1'b1;
    step();
    check("rs_drain", 32'(count), 0);

    // Random streams against a queue model.
    q.delete();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : ((i % 7) == 0);
      #1;
      check("rnd_in_ready", 32'(in_ready), 32'(q.size() != 2));
      check("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
      check("rnd_count", 32'(count), 32'(q.size()));
      if (q.size() != 0) check("rnd_data", out_data, q[0]);
      m_push = in_valid && (q.size() != 2);
      m_pop  = out_ready && (q.size() != 0);
      @(posedge clk);
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(model_ext(in_data, in_mode));
      #1;
      // Mode/data changes after acceptance must not affect stored results.
      in_mode = ~in_mode;
      in_data = ~in_data;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
